// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory bus between the instruction-fetch and data ports,
// holding each result until the pipeline advances and aborting transactions that never ack.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_INST = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic [31:0] mem_hold_q, mem_hold_d;
  logic        err_q, err_d;

  logic if_pend, mem_pend, finish, expired;

  assign mem_pend   = mem_ce_i & ~mem_done_q;
  assign if_pend    = if_ce_i & ~if_done_q;
  assign stallreq_o = mem_pend | if_pend;
  assign expired    = (cnt_q == CNT_LAST) & ~bus_ack_i;
  assign finish     = bus_ack_i | expired;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    if_hold_d  = if_hold_q;
    mem_hold_d = mem_hold_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (mem_pend)     state_d = S_DATA;
        else if (if_pend) state_d = S_INST;
      end
      S_DATA: begin
        if (finish) begin
          mem_done_d = 1'b1;
          if (!mem_we_i) mem_hold_d = bus_ack_i ? bus_rdata_i : 32'h0;
          err_d   = expired;
          cnt_d   = 8'd0;
          state_d = if_pend ? S_INST : S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_INST: begin
        if (finish) begin
          if_done_d = 1'b1;
          if_hold_d = bus_ack_i ? bus_rdata_i : 32'h0;
          err_d     = expired;
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // No stall means the pipeline moves on this edge, so held results are consumed.
    if (!stallreq_o) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_hold_q  <= 32'h0;
      mem_hold_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_hold_q  <= if_hold_d;
      mem_hold_q <= mem_hold_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_sel_o   = 4'b0000;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    case (state_q)
      S_DATA: begin
        bus_req_o   = 1'b1;
        bus_we_o    = mem_we_i;
        bus_sel_o   = mem_sel_i;
        bus_addr_o  = mem_addr_i;
        bus_wdata_o = mem_data_i;
      end
      S_INST: begin
        bus_req_o  = 1'b1;
        bus_sel_o  = 4'b1111;
        bus_addr_o = if_addr_i;
      end
      default: ;
    endcase
  end

  assign if_data_o  = if_hold_q;
  assign mem_data_o = mem_hold_q;
  assign bus_err_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data, back-to-back, write, watchdog, advance, reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt, err_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 0;
    mem_addr_i = 0; mem_data_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    tick(); tick();
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_ifdata", if_data_o, 32'h0);
    check("rst_memdata", mem_data_o, 32'h0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    rst = 1'b1;
    tick();

    // instruction only, L=1
    if_ce_i = 1; if_addr_i = 32'h0000_0010;
    #1 check("if_stall0", 32'(stallreq_o), 32'd1);
    check("if_req0", 32'(bus_req_o), 32'd0);
    tick();
    check("if_req1", 32'(bus_req_o), 32'd1);
    check("if_addr", bus_addr_o, 32'h0000_0010);
    check("if_sel", 32'(bus_sel_o), 32'hF);
    check("if_stall1", 32'(stallreq_o), 32'd1);
    bus_ack_i = 1; bus_rdata_i = 32'h3401_0020;
    tick();
    bus_ack_i = 0;
    check("if_req_done", 32'(bus_req_o), 32'd0);
    check("if_data", if_data_o, 32'h3401_0020);
    check("if_stall_low", 32'(stallreq_o), 32'd0);
    if_ce_i = 0;
    tick();
    check("if_idle_req", 32'(bus_req_o), 32'd0);

    // simultaneous: data read L=2 then fetch L=1
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0100;
    if_ce_i = 1; if_addr_i = 32'h0000_0014;
    #1 check("sim_stall0", 32'(stallreq_o), 32'd1);
    tick();
    check("sim_d_addr1", bus_addr_o, 32'h0000_0100);
    check("sim_d_we", 32'(bus_we_o), 32'd0);
    tick();
    check("sim_d_addr2", bus_addr_o, 32'h0000_0100);
    bus_ack_i = 1; bus_rdata_i = 32'hDEAD_BEEF;
    tick();
    check("sim_i_addr", bus_addr_o, 32'h0000_0014);
    check("sim_i_req", 32'(bus_req_o), 32'd1);
    check("sim_memdata", mem_data_o, 32'hDEAD_BEEF);
    check("sim_stall3", 32'(stallreq_o), 32'd1);
    bus_rdata_i = 32'h0000_0000;
    tick();
    bus_ack_i = 0;
    check("sim_stall_low", 32'(stallreq_o), 32'd0);
    check("sim_ifdata", if_data_o, 32'h0);
    check("sim_memdata2", mem_data_o, 32'hDEAD_BEEF);
    check("sim_req_low", 32'(bus_req_o), 32'd0);
    mem_ce_i = 0; if_ce_i = 0;
    tick();

    // write
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h0000_0200; mem_data_i = 32'h1234_5678;
    tick();
    check("wr_we", 32'(bus_we_o), 32'd1);
    check("wr_sel", 32'(bus_sel_o), 32'h3);
    check("wr_wdata", bus_wdata_o, 32'h1234_5678);
    bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 0;
    check("wr_memdata", mem_data_o, 32'hDEAD_BEEF);
    check("wr_stall_low", 32'(stallreq_o), 32'd0);
    mem_ce_i = 0; mem_we_i = 0;
    tick();

    // watchdog: read with no ack
    mem_ce_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0300;
    req_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_req_o) req_cnt++;
      if (bus_err_o) err_cnt++;
      if (!stallreq_o) mem_ce_i = 0;
    end
    check("wd_req_cycles", 32'(req_cnt), 32'd4);
    check("wd_err_pulses", 32'(err_cnt), 32'd1);
    check("wd_memdata", mem_data_o, 32'h0);
    check("wd_stall", 32'(stallreq_o), 32'd0);

    // ack while idle is ignored
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_F00D;
    tick();
    bus_ack_i = 0;
    check("idle_ack_if", if_data_o, 32'h0);
    check("idle_ack_mem", mem_data_o, 32'h0);

    // advance: same address re-requested after one non-stalled edge
    if_ce_i = 1; if_addr_i = 32'h0000_0040;
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA_5555;
    tick();
    bus_ack_i = 0;
    check("adv_data1", if_data_o, 32'hAAAA_5555);
    check("adv_stall_low", 32'(stallreq_o), 32'd0);
    tick();
    check("adv_restall", 32'(stallreq_o), 32'd1);
    check("adv_idle", 32'(bus_req_o), 32'd0);
    tick();
    check("adv_req", 32'(bus_req_o), 32'd1);
    check("adv_addr", bus_addr_o, 32'h0000_0040);
    bus_ack_i = 1; bus_rdata_i = 32'h1111_2222;
    tick();
    bus_ack_i = 0;
    check("adv_data2", if_data_o, 32'h1111_2222);
    if_ce_i = 0;
    tick();

    // reset mid-DATA
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0500;
    tick();
    check("rm_req_before", 32'(bus_req_o), 32'd1);
    #2 rst = 1'b0;
    #1 check("rm_req_now", 32'(bus_req_o), 32'd0);
    check("rm_ifdata", if_data_o, 32'h0);
    check("rm_addr", bus_addr_o, 32'h0);
    mem_ce_i = 0;
    #1 check("rm_stall", 32'(stallreq_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rm_idle_req", 32'(bus_req_o), 32'd0);
    check("rm_err", 32'(bus_err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
